// File: rtl/key_capture_pkg.sv
// Shared constants for the key/switch input peripheral and the top-level I/O decoder.
// Register select bits within the 0x0000_01xx I/O window.
package key_capture_pkg;

  localparam int IO_SEL_BIT     = 8;
  localparam int IO_KEY_BIT     = 4;
  localparam int IO_SW_BIT      = 5;
  localparam int IO_KEYEVT_BIT  = 6;
  localparam int IO_KEYMASK_BIT = 7;

  localparam int KC_NKEYS_DEFAULT    = 4;
  localparam int KC_NSW_DEFAULT      = 10;
  localparam int KC_DEBOUNCE_DEFAULT = 4;

  // mask_en folds the KEYMASK select into the decode only when that register exists.
  function automatic logic io_hit(input logic [31:0] addr, input logic mask_en);
    return addr[IO_SEL_BIT] &
           (addr[IO_KEY_BIT] | addr[IO_SW_BIT] | addr[IO_KEYEVT_BIT] |
            (mask_en & addr[IO_KEYMASK_BIT]));
  endfunction

endpackage

// File: rtl/key_capture_debounce.sv
// One push-button: 2-FF synchronizer on the active-low raw input, then a
// persistence counter that only accepts a level held for DEBOUNCE_CYCLES clocks.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level;

  always_comb begin
    meta_d   = key_n;
    sync_d   = meta_q;
    level    = ~sync_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any return to the accepted level restarts the count, so glitches never accumulate.
    if (level != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulse on the same edge that stable goes high, so the event lands with the level.
  assign rise    = stable_d & ~stable_q;
  assign pressed = stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/key_capture.sv
// Memory-mapped key/switch input registers (KEY, SW, KEYEVT W1C) in the 0x1xx I/O window.
// Optional macro KEY_IRQ_EN adds the KEYMASK register and a registered irq output.
module key_capture
  import key_capture_pkg::*;
#(
  parameter int NKEYS           = KC_NKEYS_DEFAULT,
  parameter int NSW             = KC_NSW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic [NSW-1:0]   sw,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  input  logic             memwrite,
  output logic [31:0]      readdata,
  output logic             hit
`ifdef KEY_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [NKEYS-1:0] key_lvl;
  logic [NKEYS-1:0] key_rise;
  logic [NSW-1:0]   sw_meta_q, sw_meta_d;
  logic [NSW-1:0]   sw_sync_q, sw_sync_d;
  logic [NKEYS-1:0] keyevt_q, keyevt_d;
  logic             wr_sel;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_n  (key_n[i]),
      .pressed(key_lvl[i]),
      .rise   (key_rise[i])
    );
  end

  assign wr_sel = memwrite & addr[IO_SEL_BIT];

  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    keyevt_d  = keyevt_q;
    if (wr_sel && addr[IO_KEYEVT_BIT]) begin
      keyevt_d = keyevt_d & ~writedata[NKEYS-1:0];
    end
    // Applied after the clear so a press coinciding with a W1C store is never lost.
    keyevt_d = keyevt_d | key_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      keyevt_q  <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      keyevt_q  <= keyevt_d;
    end
  end

`ifdef KEY_IRQ_EN
  logic [NKEYS-1:0] keymask_q, keymask_d;
  logic             irq_q, irq_d;

  always_comb begin
    keymask_d = keymask_q;
    if (wr_sel && addr[IO_KEYMASK_BIT]) begin
      keymask_d = writedata[NKEYS-1:0];
    end
    irq_d = |(keyevt_q & keymask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keymask_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      keymask_q <= keymask_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
  assign hit = io_hit(addr, 1'b1);
`else
  assign hit = io_hit(addr, 1'b0);
`endif

  // Fixed priority KEY > SW > KEYEVT > KEYMASK when several select bits are set.
  always_comb begin
    readdata = '0;
    if (hit) begin
      if (addr[IO_KEY_BIT]) begin
        readdata = 32'(key_lvl);
      end else if (addr[IO_SW_BIT]) begin
        readdata = 32'(sw_sync_q);
      end else if (addr[IO_KEYEVT_BIT]) begin
        readdata = 32'(keyevt_q);
`ifdef KEY_IRQ_EN
      end else if (addr[IO_KEYMASK_BIT]) begin
        readdata = 32'(keymask_q);
`endif
      end
    end
  end

  logic unused_bits;
`ifdef KEY_IRQ_EN
  assign unused_bits = ^{addr[31:9], addr[3:0], writedata[31:NKEYS]};
`else
  assign unused_bits = ^{addr[31:9], addr[7], addr[3:0], writedata[31:NKEYS]};
`endif

endmodule

// File: tb/tb_key_capture.sv
// Directed bench for key_capture: register reads, debounce latency, glitch rejection,
// W1C events with set-wins collision, switch sync, and irq when KEY_IRQ_EN is defined.
module tb_key_capture;

  localparam int NKEYS = 4;
  localparam int NSW   = 10;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NKEYS-1:0] key_n;
  logic [NSW-1:0]   sw;
  logic [31:0]      addr;
  logic [31:0]      writedata;
  logic             memwrite;
  logic [31:0]      readdata;
  logic             hit;
`ifdef KEY_IRQ_EN
  logic             irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_capture #(
    .NKEYS(NKEYS),
    .NSW(NSW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .sw       (sw),
    .addr     (addr),
    .writedata(writedata),
    .memwrite (memwrite),
    .readdata (readdata),
    .hit      (hit)
`ifdef KEY_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    tick(1);
    memwrite  = 1'b0;
    writedata = '0;
  endtask

  initial begin
    reset     = 1'b1;
    key_n     = '1;
    sw        = '0;
    addr      = '0;
    writedata = '0;
    memwrite  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Post-reset reads and decode
    rd("rst_key", 32'h110, 32'h0);
    chk("rst_hit_key", {31'b0, hit}, 32'h1);
    rd("rst_sw", 32'h120, 32'h0);
    rd("rst_evt", 32'h140, 32'h0);
    chk("rst_hit_evt", {31'b0, hit}, 32'h1);
    rd("nohit_rd", 32'h104, 32'h0);
    chk("nohit_hit", {31'b0, hit}, 32'h0);
`ifdef KEY_IRQ_EN
    chk("rst_irq", {31'b0, irq}, 32'h0);
`endif

    // key1 press: visible on the 6th edge after it is driven, not the 5th
    key_n = 4'b1101;
    tick(5);
    rd("k1_key_early", 32'h110, 32'h0);
    rd("k1_evt_early", 32'h140, 32'h0);
    tick(1);
    rd("k1_key", 32'h110, 32'h2);
    rd("k1_evt", 32'h140, 32'h2);

    // Release gives no event; second press leaves event at 0x2
    key_n = 4'b1111;
    tick(8);
    rd("k1_rel_key", 32'h110, 32'h0);
    rd("k1_rel_evt", 32'h140, 32'h2);
    key_n = 4'b1101;
    tick(8);
    rd("k1_again_evt", 32'h140, 32'h2);
    key_n = 4'b1111;
    tick(8);

    wr(32'h140, 32'hF);
    rd("clr_all", 32'h140, 32'h0);

    // 3-cycle glitch on key0 is rejected
    key_n = 4'b1110;
    tick(3);
    key_n = 4'b1111;
    tick(10);
    rd("glitch_key", 32'h110, 32'h0);
    rd("glitch_evt", 32'h140, 32'h0);

    // Build KEYEVT=0x3, clear bit 0 only
    key_n = 4'b1100;
    tick(6);
    rd("evt3", 32'h140, 32'h3);
    key_n = 4'b1111;
    tick(8);
    wr(32'h110, 32'hF);
    rd("wr_key_ignored", 32'h140, 32'h3);
    wr(32'h140, 32'h1);
    rd("w1c_bit0", 32'h140, 32'h2);

    // W1C of bit 0 lands on the same edge as key0's debounced press: set wins
    key_n = 4'b1110;
    tick(5);
    rd("coll_pre", 32'h140, 32'h2);
    wr(32'h140, 32'h1);
    rd("coll_setwins", 32'h140, 32'h3);
    rd("coll_key", 32'h110, 32'h1);
    wr(32'h140, 32'h0);
    rd("w1c_zero_noop", 32'h140, 32'h3);

    // Switches: two edges of latency, and read priority
    sw = 10'h2A5;
    tick(1);
    rd("sw_early", 32'h120, 32'h0);
    tick(1);
    rd("sw", 32'h120, 32'h2A5);
    rd("prio_key_sw", 32'h130, 32'h1);
    rd("prio_sw_evt", 32'h160, 32'h2A5);
    rd("prio_evt_mask", 32'h1C0, 32'h3);
    rd("nosel_rd", 32'h030, 32'h0);
    chk("nosel_hit", {31'b0, hit}, 32'h0);

`ifndef KEY_IRQ_EN
    wr(32'h180, 32'hF);
    rd("mask_absent_rd", 32'h180, 32'h0);
    chk("mask_absent_hit", {31'b0, hit}, 32'h0);
`endif

    // Reset during a debounce count discards state and pending press
    key_n = 4'b1111;
    tick(8);
    key_n = 4'b1011;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd("midrst_evt0", 32'h140, 32'h0);
    rd("midrst_sw", 32'h120, 32'h0);
    key_n = 4'b1111;
    tick(10);
    rd("midrst_evt", 32'h140, 32'h0);
    rd("midrst_key", 32'h110, 32'h0);
`ifdef KEY_IRQ_EN
    chk("midrst_irq", {31'b0, irq}, 32'h0);

    wr(32'h180, 32'h4);
    rd("mask_rd", 32'h180, 32'h4);
    chk("mask_hit", {31'b0, hit}, 32'h1);
    key_n = 4'b1011;
    tick(6);
    rd("irq_evt2", 32'h140, 32'h4);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    tick(1);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    key_n = 4'b1010;
    tick(8);
    rd("irq_evt5", 32'h140, 32'h5);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    wr(32'h140, 32'h4);
    rd("irq_clr_evt", 32'h140, 32'h1);
    chk("irq_fall_lag", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_fall", {31'b0, irq}, 32'h0);

    key_n = 4'b1111;
    tick(8);
    key_n = 4'b1011;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    key_n = 4'b1111;
    tick(10);
    chk("irq_midrst", {31'b0, irq}, 32'h0);
    rd("irq_midrst_evt", 32'h140, 32'h0);
    rd("irq_midrst_mask", 32'h180, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_capture.md
# key_capture

Memory-mapped input peripheral on the CPU data bus: the read-side counterpart of the LED/HEX output registers in the I/O window at 0x0000_01xx. It synchronizes and debounces the push-buttons and synchronizes the slide switches. Each debounced button press is latched as a sticky event that the CPU polls and clears by writing 1s. Read data is muxed into the top-level `readdata` path whenever `hit` is high.

## Interface
- `NKEYS`, default 4: number of push-buttons, 1..8.
- `NSW`, default 10: number of slide switches, 1..16.
- `DEBOUNCE_CYCLES`, default 4: `clk` cycles a changed level must persist before it is accepted, ≥1.
- `clk` in 1: system clock, the same clock the CPU runs on.
- `reset` in 1: synchronous, active-high.
- `key_n` in NKEYS: raw buttons, active-low, asynchronous.
- `sw` in NSW: raw switches, asynchronous.
- `addr` in 32: CPU byte address.
- `writedata` in 32: CPU store data.
- `memwrite` in 1: CPU store strobe.
- `readdata` out 32: register read data, combinational from `addr`.
- `hit` out 1: equals `addr[8]` and at least one of `addr[7:4]` is set.
- `irq` out 1: only present when `KEY_IRQ_EN` is defined, see Configuration.

## Operation
- Register map. The block is selected by `addr[8]=1`; one address bit selects each register.
  - `addr[4]` (0x110) KEY, RO: debounced levels, 1 = pressed.
  - `addr[5]` (0x120) SW, RO: synchronized switch levels.
  - `addr[6]` (0x140) KEYEVT, W1C: sticky press events.
  - `addr[7]` (0x180) KEYMASK, RW: present only with `KEY_IRQ_EN`.
- Read priority when several address bits are set: KEY > SW > KEYEVT > KEYMASK. Unused upper bits read 0. `readdata`=0 when `hit`=0.
- Each `key_n` bit passes through a 2-FF synchronizer, then a per-key debouncer.
  - Debouncer holds `stable` and a counter `cnt`, width $clog2(DEBOUNCE_CYCLES)+1.
  - If synced level ≠ `stable`: `cnt++`. When `cnt==DEBOUNCE_CYCLES-1`: `stable` takes the synced level and `cnt` returns to 0.
  - If synced level == `stable`: `cnt` returns to 0. A glitch shorter than DEBOUNCE_CYCLES therefore restarts the count.
- Event: on the edge where `stable` goes 0→1, the key's KEYEVT bit is set. Releases generate no event.
- Each `sw` bit passes through a 2-FF synchronizer only, with no debounce.
- Writes act when `memwrite & addr[8]`:
  - `addr[6]`: KEYEVT &= ~writedata[NKEYS-1:0].
  - `addr[7]`: KEYMASK <= writedata[NKEYS-1:0].
  - Each address bit acts independently. Writes to KEY and SW are ignored.
- Set and clear of the same KEYEVT bit on the same edge: set wins, so the event is not lost.

## Timing
- Reset values:
  - `key_n` synchronizer: all 1 (released).
  - `sw` synchronizer: 0.
  - `stable`, `cnt`, KEYEVT, KEYMASK: 0.
  - `irq`: 0.
  - Outputs after reset: `readdata` and `hit` are combinational from `addr`; KEY/SW/KEYEVT read 0 until new input propagates.
- Press latency: `key_n` is low before edge k and held low. The synchronizer output is valid after edge k+1. `stable` and KEYEVT update at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES=4 gives edge k+5).
- Switch latency: SW is readable 2 edges after `sw` changes.
- Reset asserted mid-count: all state returns to reset values on that edge, and pending events are discarded.
- `readdata` has zero latency, valid in the same cycle as `addr`.

## Configuration
- `KEY_IRQ_EN` defined:
  - Adds the `irq` port and the KEYMASK register.
  - `irq` is registered: `irq <= |(KEYEVT & KEYMASK)`, so it rises one edge after the event bit and falls one edge after the clear.
- `KEY_IRQ_EN` not defined:
  - No `irq` port and no KEYMASK flops.
  - `addr[7]` reads 0 and writes to it are ignored.
  - `hit` excludes `addr[7]`.

## Structure
- Package `key_capture_pkg`:
  - localparams `IO_SEL_BIT=8`, `IO_KEY_BIT=4`, `IO_SW_BIT=5`, `IO_KEYEVT_BIT=6`, `IO_KEYMASK_BIT=7`.
  - Default `NKEYS`.
  - Shared with the top-level decoder.
- Sub-module `debounce`: 2-FF synchronizer, counter and `stable` for one bit, with output `rise` pulse. Instantiated NKEYS times via generate.

## Test plan
- Reset, then read 0x110, 0x120, 0x140 with all keys released and SW=0: all read 0, `hit`=1; `addr`=0x104 gives `hit`=0.
- DEBOUNCE_CYCLES=4, `key_n[1]` low from edge 10:
  - KEY reads 0x2 and KEYEVT reads 0x2 after edge 15, not before.
  - Release, then press again: KEYEVT remains 0x2.
- `key_n[0]` low for 3 cycles then high (glitch): KEY and KEYEVT stay 0.
- KEYEVT=0x3, store 0x1 to 0x140: KEYEVT becomes 0x2. Store timed on the same edge as a new key0 press: KEYEVT stays 0x3.
- `sw`=0x2A5: 0x120 reads 0x2A5 after 2 edges. `addr`=0x130 reads KEY (priority).
- `KEY_IRQ_EN` defined: KEYMASK=0x4, press key2: `irq` rises one edge after KEYEVT[2]. Press key0 with mask unchanged: no `irq` change. Reset mid-debounce: `irq`=0 and no event appears.
